// File: rtl/cram_arb_if.sv
// Multi-client arbiter onto one asynchronous 16-bit PSRAM; each client word is split into BEATS memory accesses.
// Optional build macro CRAM_ARB_PRI0_EN gives channel 0 absolute priority over the round-robin channels.
module cram_arb_if #(
    parameter int AW       = 23,
    parameter int DW       = 16,
    parameter int BEATS    = 2,
    parameter int NCH      = 3,
    parameter int WAIT_CYC = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    output logic [AW-1:0]                 MEMADDR,
    inout  wire  [DW-1:0]                 MEMDQ,
    output logic                          MEMnOE,
    output logic                          MEMnWE,
    output logic                          MEMnUB,
    output logic                          MEMnLB,
    input  logic [NCH-1:0]                REQ,
    input  logic [NCH-1:0]                WE,
    input  logic [NCH*AW-1:0]             ADDR,
    input  logic [NCH*DW*BEATS-1:0]       WDATA,
    input  logic [NCH*DW*BEATS/8-1:0]     BE,
    output logic [NCH-1:0]                GNT,
    output logic [NCH-1:0]                ACK,
    output logic [DW*BEATS-1:0]           RDATA,
    output logic                          BUSY
);
    localparam int BW  = DW * BEATS;
    localparam int BEW = BW / 8;
    localparam int PW  = $clog2(NCH);
    localparam int KW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETUP   = 2'd1;
    localparam logic [1:0] S_ACCESS  = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [KW-1:0]  beat_q, beat_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [PW-1:0]  sel_q, sel_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           we_q, we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [BW-1:0]  wdata_q, wdata_d;
    logic [BEW-1:0] be_q, be_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [NCH-1:0] ack_q, ack_d;

    logic [AW-1:0]  memaddr_q, memaddr_d;
    logic           noe_q, noe_d, nwe_q, nwe_d, nub_q, nub_d, nlb_q, nlb_d;
    logic           dq_oe_q, dq_oe_d;
    logic [DW-1:0]  dq_out_q, dq_out_d;
    logic [1:0]     be_pair;

    logic           found;
    logic [PW-1:0]  win;
    logic [PW:0]    arb_idx;
    logic [PW-1:0]  sel_inc;
    logic           capture_en;

    // Round-robin search starting at the pointer, wrapping at NCH.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        arb_idx = '0;
        for (int off = 0; off < NCH; off++) begin
            arb_idx = {1'b0, ptr_q} + (PW+1)'(off);
            if (arb_idx >= (PW+1)'(NCH)) arb_idx = arb_idx - (PW+1)'(NCH);
`ifdef CRAM_ARB_PRI0_EN
            if (!found && arb_idx != '0 && REQ[arb_idx[PW-1:0]]) begin
`else
            if (!found && REQ[arb_idx[PW-1:0]]) begin
`endif
                found = 1'b1;
                win   = arb_idx[PW-1:0];
            end
        end
`ifdef CRAM_ARB_PRI0_EN
        if (REQ[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
    end

    assign sel_inc = (sel_q == PW'(NCH-1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    sel_d      = win;
                    we_d       = WE[win];
                    addr_d     = ADDR[win*AW +: AW];
                    wdata_d    = WDATA[win*BW +: BW];
                    be_d       = BE[win*BEW +: BEW];
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    beat_d     = '0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == WAIT_LAST) state_d = S_RECOVER;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            default: begin
                if (beat_q != KW'(BEATS-1)) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = S_SETUP;
                end else begin
                    ack_d[sel_q] = 1'b1;
                    gnt_d        = '0;
                    state_d      = S_IDLE;
`ifdef CRAM_ARB_PRI0_EN
                    if (sel_q != '0) ptr_d = (sel_inc == '0) ? PW'(1) : sel_inc;
`else
                    ptr_d = sel_inc;
`endif
                end
            end
        endcase
    end

    // Pin values are registered from the next state so strobes change cleanly on the clock edge.
    always_comb begin
        memaddr_d = memaddr_q;
        noe_d     = 1'b1;
        nwe_d     = 1'b1;
        nub_d     = 1'b1;
        nlb_d     = 1'b1;
        dq_oe_d   = 1'b0;
        dq_out_d  = dq_out_q;
        be_pair   = be_d[beat_d*2 +: 2];
        if (state_d != S_IDLE) begin
            memaddr_d = addr_d + AW'(beat_d);
            dq_out_d  = wdata_d[beat_d*DW +: DW];
            if (we_d) begin
                dq_oe_d = 1'b1;
                nub_d   = ~be_pair[1];
                nlb_d   = ~be_pair[0];
                nwe_d   = (state_d != S_ACCESS);
            end else begin
                noe_d = 1'b0;
                nub_d = 1'b0;
                nlb_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            memaddr_q <= '0;
            noe_q     <= 1'b1;
            nwe_q     <= 1'b1;
            nub_q     <= 1'b1;
            nlb_q     <= 1'b1;
            dq_oe_q   <= 1'b0;
            dq_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            memaddr_q <= memaddr_d;
            noe_q     <= noe_d;
            nwe_q     <= nwe_d;
            nub_q     <= nub_d;
            nlb_q     <= nlb_d;
            dq_oe_q   <= dq_oe_d;
            dq_out_q  <= dq_out_d;
        end
    end

    // Read data is sampled at the end of the last wait cycle, while nOE is still low.
    assign capture_en = (state_q == S_ACCESS) && (cnt_q == WAIT_LAST) && !we_q;

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_rdata
        logic [DW-1:0] slot_q;
        always_ff @(posedge CLK) begin
            if (RST)                                     slot_q <= '0;
            else if (capture_en && beat_q == KW'(gi))    slot_q <= MEMDQ;
        end
        assign RDATA[gi*DW +: DW] = slot_q;
    end

    assign MEMDQ   = dq_oe_q ? dq_out_q : {DW{1'bz}};
    assign MEMADDR = memaddr_q;
    assign MEMnOE  = noe_q;
    assign MEMnWE  = nwe_q;
    assign MEMnUB  = nub_q;
    assign MEMnLB  = nlb_q;
    assign GNT     = gnt_q;
    assign ACK     = ack_q;
    assign BUSY    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cram_arb_if.sv
// Directed bench for cram_arb_if: table of single-channel transactions plus round-robin and mid-transaction reset sequences.
module tb_cram_arb_if;
    logic        CLK;
    logic        RST;
    logic [22:0] MEMADDR;
    wire  [15:0] MEMDQ;
    logic        MEMnOE, MEMnWE, MEMnUB, MEMnLB;
    logic [2:0]  REQ, WE;
    logic [68:0] ADDR;
    logic [95:0] WDATA;
    logic [11:0] BE;
    logic [2:0]  GNT, ACK;
    logic [31:0] RDATA;
    logic        BUSY;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [1:0]  ch;
        logic        we;
        logic [22:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } vec_t;

    cram_arb_if dut (
        .CLK(CLK), .RST(RST), .MEMADDR(MEMADDR), .MEMDQ(MEMDQ),
        .MEMnOE(MEMnOE), .MEMnWE(MEMnWE), .MEMnUB(MEMnUB), .MEMnLB(MEMnLB),
        .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA), .BE(BE),
        .GNT(GNT), .ACK(ACK), .RDATA(RDATA), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Undriven data bus floats high so a released bus reads 0xFFFF.
    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (MEMDQ[gi]);
    end

    function automatic logic [15:0] mem_rd(input logic [22:0] a);
        if (a == 23'h7FFFFF) return 16'hBEEF;
        if (a == 23'h000000) return 16'hCAFE;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    assign MEMDQ = MEMnOE ? 16'hzzzz : mem_rd(MEMADDR);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ch(input vec_t v);
        REQ = '0; WE = '0; ADDR = '0; WDATA = '0; BE = '0;
        REQ[v.ch]               = 1'b1;
        WE[v.ch]                = v.we;
        ADDR[v.ch*23 +: 23]     = v.addr;
        WDATA[v.ch*32 +: 32]    = v.wdata;
        BE[v.ch*4 +: 4]         = v.be;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic        got;
        logic [2:0]  oh;
        logic [22:0] a;
        logic        noe_e, nwe_e, nub_e, nlb_e;
        int          beat, ph;
        int          f0;
        f0  = n_fails;
        oh  = 3'b001 << v.ch;
        got = 1'b0;
        @(negedge CLK);
        drive_ch(v);
        for (int w = 0; w < 4; w++) begin
            @(negedge CLK);
            if (GNT != 3'b000) begin
                got = 1'b1;
                break;
            end
        end
        REQ = '0;
        check({tag, "_grant"}, {61'b0, GNT}, {61'b0, oh});
        if (!got) return;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge CLK);
            beat = c / 5;
            ph   = c % 5;
            a    = v.addr + 23'(beat);
            if (v.we) begin
                noe_e = 1'b1;
                nwe_e = (ph >= 1 && ph <= 3) ? 1'b0 : 1'b1;
                nub_e = ~v.be[2*beat+1];
                nlb_e = ~v.be[2*beat];
            end else begin
                noe_e = 1'b0; nwe_e = 1'b1; nub_e = 1'b0; nlb_e = 1'b0;
            end
            check($sformatf("%s_c%0d_pins", tag, c),
                  {30'b0, MEMADDR, MEMnOE, MEMnWE, MEMnUB, MEMnLB, GNT, ACK, BUSY},
                  {30'b0, a, noe_e, nwe_e, nub_e, nlb_e, oh, 3'b000, 1'b1});
            if (v.we)
                check($sformatf("%s_c%0d_dq", tag, c), {48'b0, MEMDQ}, {48'b0, v.wdata[16*beat +: 16]});
        end
        @(negedge CLK);
        check({tag, "_ack"}, {56'b0, MEMnOE, MEMnWE, MEMnUB, MEMnLB, ACK, BUSY},
              {56'b0, 4'hF, oh, 1'b0});
        check({tag, "_dq_released"}, {48'b0, MEMDQ}, 64'h0000_0000_0000_FFFF);
        check({tag, "_rdata"}, {32'b0, RDATA}, {32'b0, v.exp_rdata});
        $display("txn %s ch=%0d we=%0d addr=0x%06h rdata=0x%08h errors=%0d",
                 tag, v.ch, v.we, v.addr, RDATA, n_fails - f0);
    endtask

    vec_t vecs[5];
    int   exp_order[4];
    int   grants[4];

    initial begin
        int          ng, viol_oh, viol_ack, g;
        logic [2:0]  prev;
        int          ack_seen;
        logic        got;
        vec_t        rv;

        vecs[0] = '{ch: 2'd1, we: 1'b1, addr: 23'h000100, wdata: 32'hA5A51234, be: 4'hF, exp_rdata: 32'h00000000};
        vecs[1] = '{ch: 2'd0, we: 1'b0, addr: 23'h7FFFFF, wdata: 32'h0,        be: 4'h0, exp_rdata: 32'hCAFEBEEF};
        vecs[2] = '{ch: 2'd2, we: 1'b1, addr: 23'h000200, wdata: 32'h55AA33CC, be: 4'h4, exp_rdata: 32'hCAFEBEEF};
        vecs[3] = '{ch: 2'd1, we: 1'b0, addr: 23'h000010, wdata: 32'h0,        be: 4'h0, exp_rdata: 32'h5A4B5A4A};
        vecs[4] = '{ch: 2'd2, we: 1'b1, addr: 23'h7FFFFF, wdata: 32'h0001F00F, be: 4'h3, exp_rdata: 32'h5A4B5A4A};
`ifdef CRAM_ARB_PRI0_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 0};
`endif

        RST = 1'b1; REQ = '0; WE = '0; ADDR = '0; WDATA = '0; BE = '0;
        repeat (3) @(negedge CLK);
        check("reset_pins", {30'b0, MEMADDR, MEMnOE, MEMnWE, MEMnUB, MEMnLB, GNT, ACK, BUSY},
              {30'b0, 23'h0, 4'hF, 3'b000, 3'b000, 1'b0});
        check("reset_rdata", {32'b0, RDATA}, 64'h0);
        check("reset_dq", {48'b0, MEMDQ}, 64'hFFFF);
        RST = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // All channels requesting continuously.
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        REQ = 3'b111; WE = 3'b000; ADDR = {23'h000040, 23'h000030, 23'h000020};
        ng = 0; viol_oh = 0; viol_ack = 0; prev = '0;
        for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
            @(negedge CLK);
            if (GNT != 3'b000 && !$onehot(GNT)) viol_oh++;
            if (ACK != 3'b000 && (!$onehot(ACK) || BUSY)) viol_ack++;
            if (GNT != 3'b000 && GNT != prev) begin
                g = 0;
                for (int i = 0; i < 3; i++) if (GNT[i]) g = i;
                grants[ng] = g;
                ng++;
            end
            prev = GNT;
        end
        REQ = '0;
        check("rr_grant_count", 64'(ng), 64'd4);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(exp_order[i]));
        check("rr_gnt_onehot_viol", 64'(viol_oh), 64'd0);
        check("rr_ack_viol", 64'(viol_ack), 64'd0);
        $display("txn rr grants=%0d,%0d,%0d,%0d errors=%0d", grants[0], grants[1], grants[2], grants[3], n_fails);

        // Reset during the first wait cycle of a write.
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        rv = '{ch: 2'd2, we: 1'b1, addr: 23'h000300, wdata: 32'h98761234, be: 4'hF, exp_rdata: 32'h0};
        drive_ch(rv);
        got = 1'b0;
        for (int w = 0; w < 4; w++) begin
            @(negedge CLK);
            if (GNT != 3'b000) begin
                got = 1'b1;
                break;
            end
        end
        REQ = '0;
        check("rst_mid_grant", {63'b0, got}, 64'd1);
        @(negedge CLK);
        check("rst_mid_access", {62'b0, MEMnWE, MEMDQ == 16'h1234}, {62'b0, 1'b0, 1'b1});
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid_pins", {54'b0, MEMnOE, MEMnWE, MEMnUB, MEMnLB, GNT, ACK, BUSY}, {54'b0, 4'hF, 3'b000, 3'b000, 1'b0});
        check("rst_mid_dq", {48'b0, MEMDQ}, 64'hFFFF);
        RST = 1'b0;
        ack_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (ACK != 3'b000) ack_seen++;
        end
        check("rst_mid_no_ack", 64'(ack_seen), 64'd0);
        $display("txn rst_mid ch=2 errors=%0d", n_fails);
        rv = '{ch: 2'd2, we: 1'b0, addr: 23'h000010, wdata: 32'h0, be: 4'h0, exp_rdata: 32'h5A4B5A4A};
        run_txn(rv, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cram_arb_if.md
Name: cram_arb_if

Overview:
- Parametrised successor to the single-master Cellular RAM interface.
- Arbitrates NCH independent client ports onto one asynchronous external PSRAM (16-bit class).
- Splits each BW-bit client word into BEATS sequential DW-bit memory accesses, with programmable access wait states.
- Sits between the bus/capture/display clients and the FPGA memory pins.

Parameters:
AW, 23, external memory address width (halfword address)
DW, 16, external memory data width; two byte lanes (nUB = DW[15:8], nLB = DW[7:0])
BEATS, 2, memory beats per client word; BW = DW*BEATS
NCH, 3, number of client channels (2..8)
WAIT_CYC, 3, CLK cycles nOE/nWE held asserted per beat (1..15)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
MEMADDR  out  AW  memory address
MEMDQ  inout  DW  memory data
MEMnOE  out  1  output enable, active-low
MEMnWE  out  1  write enable, active-low
MEMnUB  out  1  upper byte enable, active-low
MEMnLB  out  1  lower byte enable, active-low
REQ  in  NCH  per-channel request, level
WE  in  NCH  per-channel 1 = write, 0 = read
ADDR  in  NCH*AW  per-channel beat-0 halfword address; channel i occupies slice [i*AW +: AW]
WDATA  in  NCH*BW  per-channel write word; beat k = bits [k*DW +: DW]
BE  in  NCH*BW/8  per-channel byte enables; beat k uses bits [2k+1:2k]
GNT  out  NCH  one-hot, high from grant cycle through ACK
ACK  out  NCH  one-cycle completion pulse
RDATA  out  BW  read word; beat k in bits [k*DW +: DW]
BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset values: MEMADDR = 0; MEMnOE = MEMnWE = MEMnUB = MEMnLB = 1; MEMDQ tri-state; GNT = 0; ACK = 0; RDATA = 0; BUSY = 0; round-robin pointer = 0.
- States: IDLE, SETUP, ACCESS, RECOVER.
- IDLE:
  - If any REQ is set, grant the first requesting channel at or after the pointer, searching upward with wrap.
  - Latch that channel's WE, ADDR, WDATA and BE; set GNT; set beat = 0; go to SETUP.
  - Request inputs are sampled only here. Changes during a transaction are ignored.
- SETUP (1 cycle):
  - MEMADDR = latched ADDR + beat, modulo 2^AW.
  - {nUB, nLB} = ~BE for the beat on a write, 00 on a read.
  - Read: nOE = 0. Write: DQ driven with the beat data.
  - nWE = 1.
- ACCESS (WAIT_CYC cycles, counter):
  - Write: nWE = 0. Read: nOE stays 0.
  - On the last ACCESS cycle of a read, MEMDQ is captured into RDATA beat slot k.
- RECOVER (1 cycle):
  - nWE = 1. Write data stays driven for hold; nOE = 1 for a write.
  - If beat < BEATS-1: beat++, go to SETUP, with nOE kept 0 on reads.
  - Otherwise: pulse ACK[granted], clear GNT, set pointer = granted+1 mod NCH, all strobes = 1, tri-state DQ, go to IDLE.
- Latency:
  - Grant on the cycle after REQ is seen in IDLE.
  - ACK arrives BEATS*(WAIT_CYC+2) cycles after the grant cycle.
  - Minimum 1 IDLE cycle between transactions.
- RDATA is valid in the ACK cycle and holds until the next read completes. Writes do not modify RDATA.
- A write beat with BE pair 00 still executes its full timing with nUB = nLB = 1 (no byte written).
- MEMDQ is driven only from SETUP through RECOVER of write beats; tri-stated at all other times.
- Reset mid-transaction: next edge returns to IDLE with reset values; no ACK is issued; the pointer returns to 0.
- Address wrap: beat addresses wrap at 2^AW with no carry into other bits.

Optional Feature:
- Macro: CRAM_ARB_PRI0_EN.
- Defined: channel 0 has absolute priority. If REQ[0] is set in IDLE it is granted regardless of the pointer. Other channels use round-robin among themselves, and the pointer never selects 0.
- Undefined: pure round-robin across all NCH channels.

Test Plan:
- Reset, then channel 1 write with ADDR = 0x000100, WDATA = 0xA5A51234, BE = 0xF → beat 0 at 0x100 with DQ = 0x1234 and nWE low for 3 cycles; beat 1 at 0x101 with DQ = 0xA5A5; ACK[1] exactly 10 cycles after grant.
- Read from channel 0 at ADDR 0x7FFFFF with memory model returning 0xBEEF then 0xCAFE → second beat address wraps to 0x000000; RDATA = 0xCAFEBEEF in the ACK cycle; nWE stays high throughout.
- Write with BE = 0x4 → beat 0 has nUB = nLB = 1; beat 1 has nUB = 1, nLB = 0; DQ tri-stated after the final RECOVER.
- REQ = 3'b111 held continuously → grant order 0, 1, 2, 0; each GNT is one-hot; never two ACKs in one cycle. With CRAM_ARB_PRI0_EN defined, order is 0, 0, 0.
- Assert RST during ACCESS of beat 0 → the next cycle shows all strobes = 1, DQ tri-stated, BUSY = 0, no ACK; a new request then completes normally.
